// File: rtl/fp32_bf16_stream_cvt_pkg.sv
// fp_cvt_pkg: shared rounding modes, flag indices, BF16 constants and stage-1 record
package fp_cvt_pkg;
  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;
  localparam int F_NAN = 3;
  localparam int F_OVF = 2;
  localparam int F_FLUSH = 1;
  localparam int F_INX = 0;
  localparam logic [14:0] BF16_QNAN = 15'h7FFF;
  localparam logic [14:0] BF16_INF = 15'h7F80;
  localparam logic [14:0] BF16_MAXFIN = 15'h7F7F;
  typedef enum logic [2:0] {K_NORM, K_ZERO, K_DEN, K_INF, K_NAN} kind_e;
  typedef struct packed {
    kind_e kind;
    logic sign;
    logic [7:0] exp;
    logic [6:0] man;
    logic guard;
    logic inc;
    logic inx;
    logic [1:0] rmode;
  } s1_t;
endpackage

// File: rtl/fp32_bf16_stream_cvt_if.sv
// fp32_bf16_stream_cvt_if: valid/ready input and output streams of the converter
interface fp32_bf16_stream_cvt_if #(parameter int LANES = 4) ();
  logic in_valid;
  logic in_ready;
  logic [32*LANES-1:0] in_data;
  logic [1:0] in_rmode;
  logic out_valid;
  logic out_ready;
  logic [16*LANES-1:0] out_data;
  logic [3:0] out_flags;
  modport master (output in_valid, in_data, in_rmode, out_ready, input in_ready, out_valid, out_data, out_flags);
  modport slave (input in_valid, in_data, in_rmode, out_ready, output in_ready, out_valid, out_data, out_flags);
endinterface

// File: rtl/fp32_bf16_stream_cvt_lane.sv
// fp32_bf16_lane: per-lane classify/round decision (stage 1) and pack/flags (stage 2)
module fp32_bf16_lane
  import fp_cvt_pkg::*;
(
  input  logic [31:0] a,
  input  logic [1:0]  rmode,
  output s1_t         st,
  input  s1_t         r,
  output logic [15:0] res,
  output logic [3:0]  flags
);
  logic sticky, any;
  logic [7:0] man_r, exp_r;
  logic ovf, to_inf;
  always_comb begin
    sticky = |a[14:0];
    any = a[15] | sticky;
    st.kind = a[30:23] == 8'hFF ? (|a[22:0] ? K_NAN : K_INF) :
              a[30:23] == 8'h00 ? (|a[22:0] ? K_DEN : K_ZERO) : K_NORM;
    st.sign = a[31];
    st.exp = a[30:23];
    st.man = a[22:16];
    st.guard = a[15];
    st.inx = any;
    st.rmode = rmode;
    st.inc = rmode == RM_RNE ? a[15] & (sticky | a[16]) :
             rmode == RM_RUP ? any & !a[31] :
             rmode == RM_RDN ? any & a[31] : 1'b0;
  end
  // overflow is flagged whenever nearest rounding would leave the finite range, even if this mode truncates
  always_comb begin
    man_r = {1'b0, r.man} + {7'b0, r.inc};
    exp_r = r.exp + {7'b0, man_r[7]};
    ovf = r.kind == K_NORM && r.exp == 8'hFE && (&r.man) && (r.inc | r.guard);
    to_inf = r.rmode == RM_RNE || (r.rmode == RM_RUP && !r.sign) || (r.rmode == RM_RDN && r.sign);
    res = {r.sign, r.kind == K_NAN ? BF16_QNAN :
                   r.kind == K_INF ? BF16_INF :
                   r.kind != K_NORM ? 15'h0 :
                   ovf ? (to_inf ? BF16_INF : BF16_MAXFIN) : {exp_r, man_r[6:0]}};
    flags = '0;
    flags[F_NAN] = r.kind == K_NAN;
    flags[F_OVF] = ovf;
    flags[F_FLUSH] = r.kind == K_DEN;
    flags[F_INX] = r.kind == K_NORM && (r.inx | ovf);
  end
endmodule

// File: rtl/fp32_bf16_stream_cvt.sv
// fp32_bf16_stream_cvt: two-stage LANES-wide FP32 to BF16 stream converter with sticky flags
module fp32_bf16_stream_cvt
  import fp_cvt_pkg::*;
#(
  parameter int LANES = 4,
  parameter int FLAG_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flag_clr,
  output logic [3:0] sticky_flags,
  fp32_bf16_stream_cvt_if.slave s
);
  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  s1_t s1_q [LANES];
  s1_t s1_d [LANES];
  s1_t s1_c [LANES];
  logic [3:0] lane_flags [LANES];
  logic [16*LANES-1:0] res, out_data_q, out_data_d;
  logic [3:0] out_flags_q, out_flags_d, sticky_flags_q, sticky_flags_d, beat_flags;
  logic s1_advance, in_fire, out_fire, ld2;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp32_bf16_lane u_lane (
      .a(s.in_data[32*i+:32]), .rmode(s.in_rmode), .st(s1_c[i]),
      .r(s1_q[i]), .res(res[16*i+:16]), .flags(lane_flags[i])
    );
  end
  // outputs are masked during reset so no handshake can complete while rst is high
  assign s1_advance = !s2_valid_q | s.out_ready;
  assign s.in_ready = (!s1_valid_q | s1_advance) & !rst;
  assign s.out_valid = s2_valid_q & !rst;
  assign s.out_data = out_data_q;
  assign s.out_flags = out_flags_q;
  assign sticky_flags = sticky_flags_q;
  assign in_fire = s.in_valid & s.in_ready;
  assign out_fire = s.out_valid & s.out_ready;
  assign ld2 = s1_valid_q & s1_advance;
  always_comb begin
    beat_flags = '0;
    for (int k = 0; k < LANES; k++) beat_flags = beat_flags | lane_flags[k];
    for (int k = 0; k < LANES; k++) s1_d[k] = in_fire ? s1_c[k] : s1_q[k];
    s1_valid_d = in_fire | (s1_valid_q & !s1_advance);
    s2_valid_d = s1_advance ? s1_valid_q : s2_valid_q;
    out_data_d = ld2 ? res : out_data_q;
    out_flags_d = ld2 ? ((FLAG_EN != 0) ? beat_flags : 4'h0) : out_flags_q;
    sticky_flags_d = flag_clr ? 4'h0 : out_fire ? sticky_flags_q | out_flags_q : sticky_flags_q;
  end
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      out_data_q <= '0;
      out_flags_q <= '0;
      sticky_flags_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      out_data_q <= out_data_d;
      out_flags_q <= out_flags_d;
      sticky_flags_q <= sticky_flags_d;
    end
  end
endmodule

// File: tb/tb_fp32_bf16_stream_cvt.sv
// tb_fp32_bf16_stream_cvt: table, random and corner-sequence checks of the FP32->BF16 stream converter
module tb_fp32_bf16_stream_cvt;
  localparam int L = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flag_clr = 1'b0;
  logic [3:0] sticky_flags;
  fp32_bf16_stream_cvt_if #(.LANES(L)) bus ();
  fp32_bf16_stream_cvt #(.LANES(L), .FLAG_EN(1)) dut (
    .clk(clk), .rst(rst), .flag_clr(flag_clr), .sticky_flags(sticky_flags), .s(bus)
  );
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic [1:0]   rm;
    logic [63:0]  ed;
    logic [3:0]   ef;
  } vec_t;
  vec_t tbl [10];
  vec_t drv_q [$];
  vec_t exp_q [$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // reference: round the 24-bit significand to 8 bits with integer division/remainder
  function automatic void lane_model(input logic [31:0] x, input logic [1:0] rm,
                                     output logic [15:0] r, output logic [3:0] f);
    logic s;
    int e, sig, q, q0, rem, ee;
    bit up, ovf, inx, to_inf;
    s = x[31];
    e = int'(x[30:23]);
    if (e == 255) begin
      r = (x[22:0] != 0) ? {s, 15'h7FFF} : {s, 15'h7F80};
      f = (x[22:0] != 0) ? 4'b1000 : 4'b0000;
    end else if (e == 0) begin
      r = {s, 15'h0};
      f = (x[22:0] != 0) ? 4'b0010 : 4'b0000;
    end else begin
      sig = 32'h0080_0000 | int'(x[22:0]);
      q0 = sig / 65536;
      rem = sig % 65536;
      case (rm)
        2'd0: up = rem > 32768 || (rem == 32768 && q0 % 2 == 1);
        2'd1: up = 0;
        2'd2: up = rem != 0 && !s;
        default: up = rem != 0 && s;
      endcase
      q = q0 + int'(up);
      ee = e;
      if (q == 256) begin q = 128; ee = e + 1; end
      ovf = ee == 255 || (e == 254 && q0 == 255 && rem >= 32768);
      inx = rem != 0 || ovf;
      to_inf = rm == 2'd0 || (rm == 2'd2 && !s) || (rm == 2'd3 && s);
      r = ovf ? (to_inf ? {s, 15'h7F80} : {s, 15'h7F7F}) : {s, ee[7:0], q[6:0]};
      f = {1'b0, ovf, 1'b0, inx};
    end
  endfunction

  function automatic vec_t mk(input logic [127:0] d, input logic [1:0] rm);
    vec_t v;
    logic [15:0] r;
    logic [3:0] f;
    v.d = d;
    v.rm = rm;
    v.ef = '0;
    v.ed = '0;
    for (int i = 0; i < L; i++) begin
      lane_model(d[32*i+:32], rm, r, f);
      v.ed[16*i+:16] = r;
      v.ef = v.ef | f;
    end
    return v;
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(7))
      0: x[30:23] = 8'h00;
      1: x[30:23] = 8'hFF;
      2: begin x[30:23] = 8'hFE; x[22:16] = 7'h7F; end
      3: x[15:0] = 16'h8000;
      4: x[15:0] = 16'h0000;
      5: x[30:0] = 31'h7F80_0000;
      default: ;
    endcase
    return x;
  endfunction

  task automatic push(input vec_t v);
    drv_q.push_back(v);
    exp_q.push_back(v);
  endtask

  task automatic run(input int pct, input int budget);
    bit held;
    logic [67:0] last;
    int cyc;
    vec_t e;
    held = 0;
    last = '0;
    cyc = 0;
    while ((drv_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      bus.in_valid = drv_q.size() > 0;
      if (drv_q.size() > 0) begin bus.in_data = drv_q[0].d; bus.in_rmode = drv_q[0].rm; end
      bus.out_ready = $urandom_range(99) < pct;
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) void'(drv_q.pop_front());
      if (held && bus.out_valid) chk("stall_hold", {bus.out_flags, bus.out_data}, last);
      held = bus.out_valid && !bus.out_ready;
      last = {bus.out_flags, bus.out_data};
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL extra_beat: got data %h, required no beat", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 68'(bus.out_data), 68'(e.ed));
          chk("beat_flags", 68'(bus.out_flags), 68'(e.ef));
        end
      end
    end
    if (drv_q.size() > 0 || exp_q.size() > 0) begin
      n_vec++; n_bad++;
      $display("FAIL stream_timeout: %0d beats outstanding, required 0", exp_q.size());
      drv_q.delete();
      exp_q.delete();
    end
    @(posedge clk); #1;
    bus.in_valid = 0;
    bus.out_ready = 0;
  endtask

  task automatic wait_out(input string nm);
    for (int k = 0; k < 10 && !bus.out_valid; k++) @(negedge clk);
    chk(nm, 68'(bus.out_valid), 68'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{{32'h3F80C000, 32'h3F818000, 32'h3F808000, 32'h3F800000}, 2'd0, {16'h3F81, 16'h3F82, 16'h3F80, 16'h3F80}, 4'b0001};
    tbl[1] = '{{96'h0, 32'h7F7FFFFF}, 2'd0, {48'h0, 16'h7F80}, 4'b0101};
    tbl[2] = '{{96'h0, 32'h7F7FFFFF}, 2'd1, {48'h0, 16'h7F7F}, 4'b0101};
    tbl[3] = '{{96'h0, 32'h7F7FFFFF}, 2'd2, {48'h0, 16'h7F80}, 4'b0101};
    tbl[4] = '{{96'h0, 32'hFF7FFFFF}, 2'd2, {48'h0, 16'hFF7F}, 4'b0101};
    tbl[5] = '{{32'h00000000, 32'h80000001, 32'hFF800000, 32'h7FC00001}, 2'd0, {16'h0000, 16'h8000, 16'hFF80, 16'h7FFF}, 4'b1010};
    tbl[6] = '{{32'hBF800001, 32'hBF800001, 32'h3F800001, 32'h3F800001}, 2'd2, {16'hBF80, 16'hBF80, 16'h3F81, 16'h3F81}, 4'b0001};
    tbl[7] = '{{32'hBF800001, 32'hBF800001, 32'h3F800001, 32'h3F800001}, 2'd3, {16'hBF81, 16'hBF81, 16'h3F80, 16'h3F80}, 4'b0001};
    tbl[8] = '{{32'h00000000, 32'h7F800000, 32'h00800000, 32'h3FFFFFFF}, 2'd0, {16'h0000, 16'h7F80, 16'h0080, 16'h4000}, 4'b0001};
    tbl[9] = '{{96'h0, 32'hFF800000}, 2'd0, {48'h0, 16'hFF80}, 4'b0000};
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.in_rmode = '0;
    bus.out_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out_valid", 68'(bus.out_valid), 68'(0));
    chk("rst_in_ready", 68'(bus.in_ready), 68'(1));
    chk("rst_out_data", 68'(bus.out_data), 68'(0));
    chk("rst_out_flags", 68'(bus.out_flags), 68'(0));
    chk("rst_sticky", 68'(sticky_flags), 68'(0));

    // two-cycle latency with no stall
    @(posedge clk); #1;
    bus.in_valid = 1; bus.in_data = tbl[0].d; bus.in_rmode = tbl[0].rm; bus.out_ready = 1;
    @(posedge clk); #1;
    bus.in_valid = 0;
    @(negedge clk);
    chk("lat_cycle1_valid", 68'(bus.out_valid), 68'(0));
    @(negedge clk);
    chk("lat_cycle2_valid", 68'(bus.out_valid), 68'(1));
    chk("lat_cycle2_data", 68'(bus.out_data), 68'(tbl[0].ed));
    @(posedge clk); #1;
    bus.out_ready = 0;

    foreach (tbl[i]) push(tbl[i]);
    run(100, 200);
    foreach (tbl[i]) push(tbl[i]);
    run(50, 400);

    for (int i = 0; i < 20; i++) push(mk({rnd_fp(), rnd_fp(), rnd_fp(), rnd_fp()}, 2'($urandom_range(3))));
    run(50, 400);
    for (int i = 0; i < 200; i++) push(mk({rnd_fp(), rnd_fp(), rnd_fp(), rnd_fp()}, 2'($urandom_range(3))));
    run(70, 3000);

    // sticky flags: clear, overflow beat, then clear racing a NaN handshake
    @(posedge clk); #1 flag_clr = 1;
    @(posedge clk); #1 flag_clr = 0;
    push(tbl[1]);
    run(100, 50);
    @(negedge clk);
    chk("sticky_ovf", 68'(sticky_flags), 68'(4'b0101));
    @(posedge clk); #1;
    bus.in_valid = 1; bus.in_data = {96'h0, 32'h7FC00000}; bus.in_rmode = 0; bus.out_ready = 0;
    @(posedge clk); #1;
    bus.in_valid = 0;
    @(negedge clk);
    wait_out("sticky_nan_arrive");
    @(posedge clk); #1;
    bus.out_ready = 1; flag_clr = 1;
    @(posedge clk); #1;
    bus.out_ready = 0; flag_clr = 0;
    @(negedge clk);
    chk("sticky_clr_wins", 68'(sticky_flags), 68'(0));
    chk("sticky_clr_beat_gone", 68'(bus.out_valid), 68'(0));
    push(mk({96'h0, 32'hFFC00000}, 2'd0));
    run(100, 50);
    @(negedge clk);
    chk("sticky_nan", 68'(sticky_flags), 68'(4'b1000));

    // reset with two beats in flight
    @(posedge clk); #1;
    bus.out_ready = 0; bus.in_valid = 1; bus.in_data = tbl[0].d; bus.in_rmode = 0;
    @(posedge clk); #1;
    bus.in_data = tbl[5].d;
    @(posedge clk); #1;
    bus.in_valid = 0; rst = 1;
    @(negedge clk);
    chk("midrst_no_handshake", 68'(bus.out_valid), 68'(0));
    @(posedge clk); #1;
    rst = 0; bus.out_ready = 1;
    @(negedge clk);
    chk("midrst_out_valid", 68'(bus.out_valid), 68'(0));
    chk("midrst_in_ready", 68'(bus.in_ready), 68'(1));
    chk("midrst_out_data", 68'(bus.out_data), 68'(0));
    chk("midrst_sticky", 68'(sticky_flags), 68'(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midrst_no_stale", 68'(bus.out_valid), 68'(0));
    end
    push(tbl[8]);
    run(100, 50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
